// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round constants, IVs, FSM/mode encodings and
// the FIPS 180-4 round helper functions.
package sha2_pkg;

  localparam int unsigned NumRounds = 64;

  typedef logic [31:0] word_t;
  // Element 0 is H0/a and sits in the most significant bits.
  typedef logic [0:7][31:0] hash_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUNDS,
    FINAL
  } sha2_state_e;

  typedef enum logic {
    MODE_SHA256 = 1'b0,
    MODE_SHA224 = 1'b1
  } sha2_mode_e;

  localparam hash_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam hash_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam word_t K [NumRounds] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic hash_t iv_sel(input sha2_mode_e mode);
    return (mode == MODE_SHA224) ? IV224 : IV256;
  endfunction

endpackage

// File: rtl/sha2_w_sched.sv
// 16-word sliding message schedule; presents W[t..t+R-1] and advances by R.
module sha2_w_sched
  import sha2_pkg::*;
#(
  parameter int unsigned RoundsPerCycle = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           load_i,
  input  logic                           shift_i,
  input  logic [511:0]                   block_i,
  output logic [RoundsPerCycle-1:0][31:0] w_o
);

  word_t win_q [16];
  word_t ext   [16 + RoundsPerCycle];

  // Extend the window by R words; later expansions feed on earlier ones.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      ext[i] = win_q[i];
    end
    for (int unsigned j = 0; j < RoundsPerCycle; j++) begin
      ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j]
                  + small_sigma0(ext[1 + j]) + ext[j];
      w_o[j]      = win_q[j];
    end
  end

  // Window register: load on accept, slide by R while rounds run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else if (load_i) begin
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= block_i[511 - 32 * i -: 32];
      end
    end else if (shift_i) begin
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= ext[i + RoundsPerCycle];
      end
    end
  end

endmodule

// File: rtl/sha2_iter_core.sv
// Iterative SHA-256/SHA-224 compression core, R rounds per clock.
module sha2_iter_core
  import sha2_pkg::*;
#(
  parameter int unsigned BlockWidth     = 512,
  parameter int unsigned RoundsPerCycle = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  init_i,
  input  logic                  next_i,
  input  logic                  mode_i,
  input  logic [BlockWidth-1:0] block_i,
  output logic                  ready_o,
  output logic [6:0]            round_o,
  output logic [255:0]          digest_o,
  output logic                  digest_valid_o
);

  if (BlockWidth != 512) begin : g_bad_block_width
    $error("sha2_iter_core: BlockWidth must be 512");
  end
  if (!(RoundsPerCycle == 1 || RoundsPerCycle == 2 || RoundsPerCycle == 4)) begin : g_bad_rpc
    $error("sha2_iter_core: RoundsPerCycle must be 1, 2 or 4");
  end

  sha2_state_e state_q, state_d;
  sha2_mode_e  mode_q;
  hash_t       h_q, work_q, work_d, h_sum;
  logic [6:0]  rnd_q;
  logic        valid_q;
  logic        accept;
  logic        last_step;
  logic [RoundsPerCycle-1:0][31:0] w_win;

  assign accept    = (state_q == IDLE) && (init_i || next_i);
  assign last_step = (rnd_q + 7'(RoundsPerCycle)) == 7'(NumRounds);

  sha2_w_sched #(
    .RoundsPerCycle(RoundsPerCycle)
  ) u_w_sched (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (accept),
    .shift_i(state_q == ROUNDS),
    .block_i(block_i),
    .w_o    (w_win)
  );

  // R-deep unrolled compression rounds on the working variables a..h.
  always_comb begin
    logic [5:0] k_idx;
    word_t      t1, t2;
    k_idx  = '0;
    t1     = '0;
    t2     = '0;
    work_d = work_q;
    for (int unsigned j = 0; j < RoundsPerCycle; j++) begin
      k_idx  = rnd_q[5:0] + 6'(j);
      t1     = work_d[7] + big_sigma1(work_d[4]) + ch(work_d[4], work_d[5], work_d[6])
             + K[k_idx] + w_win[j];
      t2     = big_sigma0(work_d[0]) + maj(work_d[0], work_d[1], work_d[2]);
      work_d = {t1 + t2, work_d[0], work_d[1], work_d[2],
                work_d[3] + t1, work_d[4], work_d[5], work_d[6]};
    end
  end

  // Word-wise feed-forward of the working variables into the hash state.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + work_q[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ROUNDS;
      ROUNDS:  if (last_step) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hash state, working variables, round counter and result flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q     <= IV256;
      work_q  <= '0;
      rnd_q   <= '0;
      mode_q  <= MODE_SHA256;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (init_i) begin
              mode_q <= sha2_mode_e'(mode_i);
              h_q    <= iv_sel(sha2_mode_e'(mode_i));
              work_q <= iv_sel(sha2_mode_e'(mode_i));
            end else begin
              work_q <= h_q;
            end
            rnd_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        ROUNDS: begin
          work_q <= work_d;
          rnd_q  <= rnd_q + 7'(RoundsPerCycle);
        end
        FINAL: begin
          h_q     <= h_sum;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign round_o        = rnd_q;
  assign digest_valid_o = valid_q;
  assign digest_o       = (mode_q == MODE_SHA224) ? {h_q[0:6], 32'h0} : h_q;

endmodule

// File: tb/tb_sha2_iter_core.sv
// Self-checking bench: three cores (R = 1, 2, 4) against a whole-block
// behavioural SHA-256 model plus known-answer digests.
module tb_sha2_iter_core;

  localparam logic [255:0] TB_IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] TB_IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] TBK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] BLK_2A  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B  = {448'h0, 64'h1c0};

  localparam logic [255:0] KAT_ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] KAT_ABC224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] KAT_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst_s   [3];
  logic         init_s  [3];
  logic         next_s  [3];
  logic         mode_s  [3];
  logic [511:0] blk_s   [3];
  logic         ready_s [3];
  logic [6:0]   round_s [3];
  logic [255:0] dig_s   [3];
  logic         valid_s [3];

  logic [255:0] mh    [3];
  logic         mmode [3];

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha2_iter_core #(
      .BlockWidth    (512),
      .RoundsPerCycle(1 << g)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_s[g]),
      .init_i        (init_s[g]),
      .next_i        (next_s[g]),
      .mode_i        (mode_s[g]),
      .block_i       (blk_s[g]),
      .ready_o       (ready_s[g]),
      .round_o       (round_s[g]),
      .digest_o      (dig_s[g]),
      .digest_valid_o(valid_s[g])
    );
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Whole-block compression: full 64-word schedule up front, then 64 rounds.
  function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32 * i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TBK[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32 * i -: 32] = v[i] + hin[255 - 32 * i -: 32];
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i * 32 +: 32] = $urandom;
    return r;
  endfunction

  // One command on instance k; optionally pokes commands mid-run.
  task automatic cmd(input int k, input bit di, input bit dn, input bit md,
                     input logic [511:0] blk, input bit poke);
    int cyc, rerr, exp_r;
    logic [255:0] base, exp;
    check("ready_pre", 256'(ready_s[k]), 256'(1));
    @(negedge clk);
    init_s[k] = di; next_s[k] = dn; mode_s[k] = md; blk_s[k] = blk;
    @(posedge clk); #1;
    init_s[k] = 1'b0; next_s[k] = 1'b0; mode_s[k] = 1'($urandom); blk_s[k] = rand512();
    if (di) begin
      mmode[k] = md;
      base = md ? TB_IV224 : TB_IV256;
    end else begin
      base = mh[k];
    end
    mh[k] = model_compress(base, blk);
    exp   = mmode[k] ? {mh[k][255:32], 32'h0} : mh[k];
    check("acc_ready", 256'(ready_s[k]), 256'(0));
    check("acc_valid", 256'(valid_s[k]), 256'(0));
    check("acc_round", 256'(round_s[k]), 256'(0));
    cyc = 0; rerr = 0;
    while (!valid_s[k] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 3) begin
        init_s[k] = 1'b1; next_s[k] = 1'b1; mode_s[k] = ~md;
      end
      if (poke && cyc == 4) begin
        init_s[k] = 1'b0; next_s[k] = 1'b0;
      end
      if (!valid_s[k]) begin
        exp_r = (cyc * (1 << k) > 64) ? 64 : cyc * (1 << k);
        if (int'(round_s[k]) != exp_r || ready_s[k]) rerr++;
      end
    end
    init_s[k] = 1'b0; next_s[k] = 1'b0;
    check("latency",    256'(cyc), 256'((64 >> k) + 1));
    check("round_prog", 256'(rerr), 256'(0));
    check("ready_done", 256'(ready_s[k]), 256'(1));
    check("round_done", 256'(round_s[k]), 256'(64));
    check("digest",     dig_s[k], exp);
  endtask

  // Start an init, then pull reset once round_o reaches at_round.
  task automatic abort_run(input int k, input logic [511:0] blk, input int at_round);
    int cyc;
    @(negedge clk);
    init_s[k] = 1'b1; mode_s[k] = 1'b0; blk_s[k] = blk;
    @(posedge clk); #1;
    init_s[k] = 1'b0;
    cyc = 0;
    while (int'(round_s[k]) < at_round && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach", 256'(cyc < 200), 256'(1));
    rst_s[k] = 1'b0;
    #1;
    check("rst_ready",  256'(ready_s[k]), 256'(1));
    check("rst_valid",  256'(valid_s[k]), 256'(0));
    check("rst_round",  256'(round_s[k]), 256'(0));
    check("rst_digest", dig_s[k], TB_IV256);
    @(posedge clk); #1;
    check("rst_hold_valid", 256'(valid_s[k]), 256'(0));
    @(negedge clk);
    rst_s[k] = 1'b1;
    mh[k] = TB_IV256;
    mmode[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b0; init_s[k] = 1'b0; next_s[k] = 1'b0;
      mode_s[k] = 1'b0; blk_s[k] = '0;
      mh[k] = TB_IV256; mmode[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      check("reset_ready", 256'(ready_s[k]), 256'(1));
      check("reset_valid", 256'(valid_s[k]), 256'(0));
      check("reset_round", 256'(round_s[k]), 256'(0));
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b1;

    for (int k = 0; k < 3; k++) begin
      cmd(k, 1'b1, 1'b0, 1'b0, BLK_ABC, 1'b0);
      check("kat_abc256", dig_s[k], KAT_ABC256);
      repeat (3) @(posedge clk);
      #1 check("valid_hold", 256'(valid_s[k]), 256'(1));

      cmd(k, 1'b1, 1'b0, 1'b1, BLK_ABC, 1'b0);
      check("kat_abc224", dig_s[k], KAT_ABC224);

      cmd(k, 1'b1, 1'b0, 1'b0, BLK_2A, 1'b0);
      cmd(k, 1'b0, 1'b1, 1'b1, BLK_2B, 1'b0);
      check("kat_two_block", dig_s[k], KAT_TWO);

      cmd(k, 1'b1, 1'b0, 1'b0, BLK_ABC, 1'b1);
      check("kat_busy_ignored", dig_s[k], KAT_ABC256);

      cmd(k, 1'b1, 1'b1, 1'b1, BLK_ABC, 1'b0);
      check("kat_init_wins", dig_s[k], KAT_ABC224);

      abort_run(k, BLK_ABC, 30);
      cmd(k, 1'b1, 1'b0, 1'b0, BLK_ABC, 1'b0);
      check("kat_after_reset", dig_s[k], KAT_ABC256);

      abort_run(k, rand512(), 12);
      cmd(k, 1'b0, 1'b1, 1'b1, rand512(), 1'b0);

      for (int n = 0; n < 6; n++) begin
        bit di, dn;
        di = 1'($urandom_range(0, 2) == 0);
        dn = ~di | 1'($urandom);
        cmd(k, di, dn, 1'($urandom), rand512(), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha2_iter_core.md
Name: sha2_iter_core

Overview:
- Iterative SHA-2 compression engine for SHA-256 and SHA-224, selected at run time.
- Processes one pre-padded 512-bit block per command, configurable 1/2/4 rounds per clock.
- Chains blocks by keeping the hash state between commands (init/next).
- Sits between the padding/block-assembly front end and the digest register interface.

Parameters:
- BlockWidth, 512, message block width in bits; only 512 is legal (elaboration assertion).
- RoundsPerCycle, 1, compression rounds per clock; legal values 1, 2, 4 (elaboration assertion).
- NumRounds, 64, total rounds per block; fixed, derived from the algorithm.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- init_i  in  1  start first block of a new message; loads IV selected by mode_i
- next_i  in  1  start next block of the current message using the held hash state
- mode_i  in  1  0 = SHA-256, 1 = SHA-224; sampled only with an accepted init_i
- block_i  in  BlockWidth  padded block, word W0 in bits [511:480]; sampled on the accept edge
- ready_o  out  1  core idle, can accept init_i/next_i
- round_o  out  7  rounds completed on the current block, 0..64
- digest_o  out  256  hash state H0..H7 (SHA-224: H0..H6 in [255:32], [31:0] = 0)
- digest_valid_o  out  1  digest_o holds the result of the last completed block

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low, rst_ni.
- Reset values:
  - state IDLE
  - ready_o = 1, digest_valid_o = 0, round_o = 0
  - H registers = SHA-256 IV, a..h = 0, W window = 0, latched mode = SHA-256
  - digest_o reflects H; it is meaningful only while digest_valid_o is 1.
- FSM states: IDLE, ROUNDS, FINAL.
- IDLE:
  - ready_o = 1.
  - Command accept is the edge where ready_o && (init_i || next_i).
  - init_i:
    - latch mode_i.
    - H <- IV(mode_i); a..h <- IV(mode_i).
  - next_i: a..h <- H; mode unchanged.
  - Either command:
    - W window <- block_i.
    - round counter <- 0.
    - digest_valid_o <- 0.
    - go to ROUNDS.
  - init_i && next_i together: init_i wins.
  - next_i with no prior init since reset: uses the reset H (SHA-256 IV). Legal, and equivalent to an init with mode 0.
- ROUNDS:
  - ready_o = 0.
  - Each cycle performs RoundsPerCycle rounds t..t+R-1 with K[t] and W[t].
  - W[t] comes from a 16-word sliding window. For t >= 16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32.
  - The round counter advances by R.
  - After the cycle in which the counter reaches 64, go to FINAL.
  - Duration is 64/R cycles.
- FINAL:
  - H_i <- H_i + a..h (word-wise, mod 2^32).
  - digest_valid_o <- 1 and ready_o <- 1 on the same edge; go to IDLE.
- Latency: with command accepted at edge T, digest_valid_o and ready_o rise at edge T + 64/R + 1.
  - R=1: 65 cycles; R=4: 17 cycles.
  - Back-to-back next_i is accepted on the very edge ready_o is seen high.
- Commands while busy: init_i/next_i are ignored while ready_o = 0; the source must hold or re-issue them.
- Inputs while busy: block_i and mode_i are don't-care outside the accept edge.
- Arithmetic: all additions are 32-bit and wrap.
  - Σ0/Σ1/σ0/σ1 use the FIPS 180-4 rotate/shift amounts.
  - SHA-224 uses identical rounds; only the IV and the output truncation differ.
- digest_valid_o:
  - stays 1 in IDLE until the next accepted command;
  - drops on the accept edge.
- round_o:
  - counts 0..64 during ROUNDS;
  - holds 64 in FINAL and afterwards;
  - returns to 0 on accept.
- Reset mid-operation: asynchronous return to reset values; the partial digest is lost and no digest_valid_o pulse occurs.

Decomposition:
- Package sha2_pkg holds:
  - K[64] constant array;
  - IV256 and IV224 constants;
  - FSM state enum (IDLE/ROUNDS/FINAL);
  - Σ0, Σ1, σ0, σ1, Ch, Maj functions;
  - mode encoding constants.
- Sub-module sha2_w_sched: the 16 x 32-bit sliding message schedule.
  - Load-on-accept, shift by R per cycle.
  - Outputs W[t..t+R-1].
  - Clocked by clk_i with rst_ni.
- The round datapath stays in the core as an R-deep combinational unroll.

Test Plan:
- SHA-256 single block: init_i with padded "abc", mode 0 -> digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; digest_valid_o rises exactly 65 cycles after accept (R=1).
- SHA-224 single block: padded "abc", mode 1 -> digest_o[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, and [31:0] = 0.
- Two-block chaining: init_i with block 1 of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", then next_i with block 2 on the ready edge -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; digest_valid_o low between the blocks.
- Busy and priority: pulse init_i/next_i during ROUNDS -> ignored, same "abc" digest; init_i && next_i together in IDLE -> IV reload (init behaviour).
- Reset mid-operation: assert rst_ni low at round 30 -> next cycle ready_o = 1, digest_valid_o = 0, round_o = 0; re-run "abc" and obtain the correct digest.
- Parameter sweep: repeat the tests above with R = 2 and R = 4 -> identical digests, with latency 33 and 17 cycles respectively.
